// File: rtl/csr_bank.sv
// Generic CSR register bank.
// Decodes host CSR requests over a valid/ready request/response channel.
// Each register is one of:
//   - RW: stored in the bank;
//   - read-only: mirrors a hardware input;
//   - lockable: writes are refused while the core is busy.
// Bits in SelfClrMask are write-1 pulses that are never read back.
module csr_bank #(
  parameter int unsigned NumRegs   = 13,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter logic [NumRegs-1:0]           RoRegMask   = '0,
  parameter logic [NumRegs-1:0]           LockRegMask = '0,
  parameter logic [NumRegs*DataWidth-1:0] SelfClrMask = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [AddrWidth-1:0]           csr_req_addr_i,
  input  logic [DataWidth-1:0]           csr_req_data_i,
  input  logic                           csr_req_write_i,
  input  logic                           csr_req_valid_i,
  output logic                           csr_req_ready_o,
  output logic [DataWidth-1:0]           csr_rsp_data_o,
  output logic                           csr_rsp_err_o,
  output logic                           csr_rsp_valid_o,
  input  logic                           csr_rsp_ready_i,
  input  logic                           csr_busy_i,
  input  logic [NumRegs*DataWidth-1:0]   csr_reg_ro_i,
  output logic [NumRegs*DataWidth-1:0]   csr_reg_set_o,
  output logic [NumRegs-1:0]             csr_wr_pulse_o
);

  typedef logic [DataWidth-1:0] word_t;

  // Per-register views of the flattened vectors.
  word_t [NumRegs-1:0] sc_mask;
  word_t [NumRegs-1:0] ro_view;

  // Stored register contents; RO registers are held at zero.
  word_t [NumRegs-1:0] reg_q, reg_d;
  logic  [NumRegs-1:0] pulse_q, pulse_d;

  // One-entry response register.
  logic  rsp_valid_q, rsp_valid_d;
  logic  rsp_err_q, rsp_err_d;
  word_t rsp_data_q, rsp_data_d;

  // Request decode.
  logic [NumRegs-1:0] addr_hit;
  logic               addr_ok;
  logic               hit_ro;
  logic               hit_lock;
  logic               req_fire;
  logic               req_err;
  logic               wr_ok;
  word_t              rd_value;

  assign sc_mask = SelfClrMask;
  assign ro_view = csr_reg_ro_i;

  // A new request can enter whenever the response slot is empty or is being drained now.
  assign csr_req_ready_o = !rsp_valid_q || csr_rsp_ready_i;
  assign req_fire        = csr_req_valid_i && csr_req_ready_o;

  // Full-width address compare so out-of-range addresses never alias onto a register.
  always_comb begin
    addr_hit = '0;
    for (int i = 0; i < NumRegs; i++) begin
      addr_hit[i] = (csr_req_addr_i == AddrWidth'(i));
    end
  end

  assign addr_ok  = |addr_hit;
  assign hit_ro   = |(addr_hit & RoRegMask);
  assign hit_lock = |(addr_hit & LockRegMask);

  // Reject unknown addresses, writes to RO registers and writes to locked registers while busy.
  assign req_err = !addr_ok
                || (csr_req_write_i && hit_ro)
                || (csr_req_write_i && hit_lock && csr_busy_i);
  assign wr_ok   = req_fire && csr_req_write_i && !req_err;

  // Read mux: RO registers show the live hardware value, others the stored value minus pulse bits.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (addr_hit[i]) begin
        rd_value = RoRegMask[i] ? ro_view[i] : (reg_q[i] & ~sc_mask[i]);
      end
    end
  end

  // Next register contents: pulse bits drop every cycle unless rewritten; RO registers stay zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    reg_d   = reg_q & ~sc_mask;
    pulse_d = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (wr_ok && addr_hit[i]) begin
        reg_d[i]   = csr_req_data_i;
        pulse_d[i] = 1'b1;
      end
      if (RoRegMask[i]) begin
        reg_d[i] = '0;
      end
    end
  end

  // Response slot: load on accept, otherwise hold until consumed.
  always_comb begin
    rsp_valid_d = rsp_valid_q && !csr_rsp_ready_i;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_data_d  = (req_err || csr_req_write_i) ? '0 : rd_value;
    end
  end

  // State registers; every bit, including the register file, returns to zero on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state is assigned with <= so all flops update from pre-edge values.
      reg_q       <= '0;
      pulse_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      reg_q       <= reg_d;
      pulse_q     <= pulse_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign csr_reg_set_o   = reg_q;
  assign csr_wr_pulse_o  = pulse_q;
  assign csr_rsp_valid_o = rsp_valid_q;
  assign csr_rsp_err_o   = rsp_err_q;
  assign csr_rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_csr_bank.sv
// Self-checking bench for csr_bank.
// Runs directed vector tables and hand sequences for stall, self-clear and reset,
// then random traffic checked against a behavioural model.
module tb_csr_bank;

  localparam int NR = 13;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [NR-1:0]    RO_MASK   = 13'h0084;  // regs 2, 7
  localparam logic [NR-1:0]    LOCK_MASK = 13'h0A00;  // regs 9, 11
  localparam logic [NR*DW-1:0] SC_MASK   = ((NR*DW)'(32'h0000_00F0) << (5*DW)) | (NR*DW)'(1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_data;
  logic              req_write;
  logic              req_valid;
  logic              req_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              busy;
  logic [NR*DW-1:0]  ro_in;
  logic [NR*DW-1:0]  reg_set;
  logic [NR-1:0]     wr_pulse;

  csr_bank #(
    .NumRegs(NR), .DataWidth(DW), .AddrWidth(AW),
    .RoRegMask(RO_MASK), .LockRegMask(LOCK_MASK), .SelfClrMask(SC_MASK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .csr_req_addr_i(req_addr), .csr_req_data_i(req_data),
    .csr_req_write_i(req_write), .csr_req_valid_i(req_valid),
    .csr_req_ready_o(req_ready),
    .csr_rsp_data_o(rsp_data), .csr_rsp_err_o(rsp_err),
    .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
    .csr_busy_i(busy), .csr_reg_ro_i(ro_in),
    .csr_reg_set_o(reg_set), .csr_wr_pulse_o(wr_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_reg [NR];  // readable (non-pulse) content per register
  logic [DW-1:0] m_sc  [NR];  // pulse bits visible this cycle
  logic [NR-1:0] m_pulse;
  logic          m_rsp_valid;
  logic          m_rsp_err;
  logic [DW-1:0] m_rsp_data;

  function automatic logic [DW-1:0] sc_of(input int i);
    return SC_MASK[i*DW +: DW];
  endfunction

  function automatic logic [NR*DW-1:0] exp_set();
    logic [NR*DW-1:0] v = '0;
    for (int i = 0; i < NR; i++) begin
      if (!RO_MASK[i]) v[i*DW +: DW] = m_reg[i] | m_sc[i];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_sc[i]  = '0;
    end
    m_pulse     = '0;
    m_rsp_valid = 1'b0;
    m_rsp_err   = 1'b0;
    m_rsp_data  = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    logic fire;
    logic in_range;
    logic err;
    int   idx;
    fire     = req_valid && (!m_rsp_valid || rsp_ready);
    m_pulse  = '0;
    for (int i = 0; i < NR; i++) m_sc[i] = '0;
    if (fire) begin
      in_range = (req_addr < NR);
      idx      = in_range ? int'(req_addr) : 0;
      err      = !in_range || (req_write && RO_MASK[idx]) || (req_write && LOCK_MASK[idx] && busy);
      m_rsp_valid = 1'b1;
      m_rsp_err   = err;
      if (err || req_write) m_rsp_data = '0;
      else                  m_rsp_data = RO_MASK[idx] ? ro_in[idx*DW +: DW] : m_reg[idx];
      if (!err && req_write) begin
        m_reg[idx]   = req_data & ~sc_of(idx);
        m_sc[idx]    = req_data & sc_of(idx);
        m_pulse[idx] = 1'b1;
      end
    end else if (rsp_ready) begin
      m_rsp_valid = 1'b0;
    end
  endtask

  // ---------------- directed helpers ----------------
  // Issue one request with the response side ready; returns at accept edge + 1.
  task automatic xact(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic bsy, output logic [DW-1:0] rd, output logic er);
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    busy      = bsy;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("xact_rsp_valid", rsp_valid, 1'b1);
    rd = rsp_data;
    er = rsp_err;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
    logic          exp_err;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [DW-1:0]    rd;
    logic             er;
    logic [NR-1:0]    exp_p;
    logic [NR*DW-1:0] exp_v;
    logic [AW-1:0]    s_addr [4];
    logic [DW-1:0]    s_data [4];

    vecs[0]  = '{1'b1, 32'd4,          32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'd4,          32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'd2,          32'h0,        1'b0, 1'b0, 32'h105};
    vecs[3]  = '{1'b1, 32'd2,          32'hFF,       1'b0, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'd2,          32'h0,        1'b0, 1'b0, 32'h105};
    vecs[5]  = '{1'b1, 32'd9,          32'h3,        1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'd9,          32'h0,        1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'd9,          32'h3,        1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'd9,          32'h0,        1'b1, 1'b0, 32'h3};
    vecs[9]  = '{1'b0, 32'd13,         32'h0,        1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'h0,        1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 32'd13,         32'h1234,     1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h8000_0004,  32'h1111,     1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'd4,          32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[14] = '{1'b1, 32'd3,          32'h77,       1'b1, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'd3,          32'h0,        1'b0, 1'b0, 32'h77};
    vecs[16] = '{1'b1, 32'd11,         32'h55,       1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'd11,         32'h0,        1'b1, 1'b0, 32'h55};
    vecs[18] = '{1'b0, 32'd7,          32'h0,        1'b0, 1'b0, 32'hCAFE0007};

    rst_n     = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_write = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    busy      = 1'b0;
    ro_in     = '0;
    ro_in[2*DW +: DW] = 32'h105;
    ro_in[7*DW +: DW] = 32'hCAFE0007;

    // Reset state
    #12;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_pulse", wr_pulse, '0);
    check("rst_reg_set", reg_set, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      xact(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].busy, rd, er);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      exp_p = (vecs[i].wr && !vecs[i].exp_err) ? (NR'(1) << vecs[i].addr[3:0]) : '0;
      check($sformatf("vec%0d_pulse", i), wr_pulse, exp_p);
    end
    exp_v = '0;
    exp_v[3*DW +: DW]  = 32'h77;
    exp_v[4*DW +: DW]  = 32'hDEADBEEF;
    exp_v[9*DW +: DW]  = 32'h3;
    exp_v[11*DW +: DW] = 32'h55;
    check("table_reg_set", reg_set, exp_v);

    // Self-clear: written 1 visible one cycle, read masked
    xact(1'b1, 32'd0, 32'h9, 1'b0, rd, er);
    check("sc_w9_set", reg_set[0 +: DW], 32'h9);
    @(posedge clk); #1;
    check("sc_w9_after", reg_set[0 +: DW], 32'h8);
    check("sc_pulse_gone", wr_pulse, '0);
    xact(1'b0, 32'd0, 32'h0, 1'b0, rd, er);
    check("sc_read", rd, 32'h8);
    xact(1'b1, 32'd0, 32'h1, 1'b0, rd, er);
    check("sc_b2b_1", reg_set[0 +: DW], 32'h1);
    xact(1'b1, 32'd0, 32'h1, 1'b0, rd, er);
    check("sc_b2b_2", reg_set[0 +: DW], 32'h1);
    @(posedge clk); #1;
    check("sc_b2b_end", reg_set[0 +: DW], 32'h0);
    xact(1'b1, 32'd5, 32'hFF, 1'b0, rd, er);
    check("sc_r5_set", reg_set[5*DW +: DW], 32'hFF);
    xact(1'b0, 32'd5, 32'h0, 1'b0, rd, er);
    check("sc_r5_raw_read", rd, 32'h0F);
    check("sc_r5_after", reg_set[5*DW +: DW], 32'h0F);

    // Read-after-write back-to-back
    xact(1'b1, 32'd8, 32'hA5A5_0001, 1'b0, rd, er);
    xact(1'b0, 32'd8, 32'h0, 1'b0, rd, er);
    check("raw_data", rd, 32'hA5A5_0001);

    // Stall: 4 back-to-back reads with response side stalled 3 cycles
    s_addr[0] = 32'd4;  s_data[0] = 32'hDEADBEEF;
    s_addr[1] = 32'd9;  s_data[1] = 32'h3;
    s_addr[2] = 32'd11; s_data[2] = 32'h55;
    s_addr[3] = 32'd3;  s_data[3] = 32'h77;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_write = 1'b0;
    req_valid = 1'b1;
    req_addr  = s_addr[0];
    #1;
    check("stall_ready_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    req_addr = s_addr[1];
    for (int s = 0; s < 3; s++) begin
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_data", rsp_data, s_data[0]);
      check("stall_err", rsp_err, 1'b0);
      check("stall_ready", req_ready, 1'b0);
      if (s < 2) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_release_ready", req_ready, 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("stream%0d_valid", k), rsp_valid, 1'b1);
      check($sformatf("stream%0d_data", k), rsp_data, s_data[k]);
      if (k < 3) req_addr = s_addr[k+1];
      else       req_valid = 1'b0;
    end
    @(posedge clk); #1;
    check("stream_drained", rsp_valid, 1'b0);

    // Reset mid-transaction
    rsp_ready = 1'b0;
    req_write = 1'b1;
    req_addr  = 32'd6;
    req_data  = 32'h66;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_valid", rsp_valid, 1'b1);
    check("pre_rst_pulse", wr_pulse, NR'(1) << 6);
    check("pre_rst_r6", reg_set[6*DW +: DW], 32'h66);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_reg_set", reg_set, '0);
    check("mid_rst_pulse", wr_pulse, '0);
    check("mid_rst_data", rsp_data, '0);
    check("mid_rst_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("no_replay", rsp_valid, 1'b0);
    xact(1'b0, 32'd4, 32'h0, 1'b0, rd, er);
    check("post_rst_r4", rd, 32'h0);

    // Random traffic against the model
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid) begin
        check("rnd_rsp_data", rsp_data, m_rsp_data);
        check("rnd_rsp_err", rsp_err, m_rsp_err);
      end
      check("rnd_pulse", wr_pulse, m_pulse);
      check("rnd_reg_set", reg_set, exp_set());
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, 14));
      req_data  = $urandom;
      busy      = $urandom_range(0, 1) == 1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) ro_in[i*DW +: DW] = $urandom;
      #1;
      check("rnd_ready", req_ready, !m_rsp_valid || rsp_ready);
      model_step();
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Parametrised CSR register bank that replaces hand-coded per-register decode with one generic bank.
- Sits between the host CSR bus and the core and instruction controllers.
- Provides a valid/ready request/response channel.
- Supports per-register access modes (RW, read-only hardware-driven, busy-locked) and per-bit self-clearing pulse bits.
- Supports error responses and one-cycle write strobes.

Parameters:
- NumRegs, 13, number of 32-bit-addressed CSR registers (word index = address).
- DataWidth, 32, register width.
- AddrWidth, 32, request address width.
- RoRegMask, NumRegs'b0, bit i=1: register i is read-only and reflects csr_reg_ro_i slice i.
- LockRegMask, NumRegs'b0, bit i=1: writes to register i are rejected while csr_busy_i=1.
- SelfClrMask, (NumRegs*DataWidth)'b0, flattened; bit set = write-1 pulse bit that self-clears.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_req_addr_i  in  AddrWidth  register index
- csr_req_data_i  in  DataWidth  write data
- csr_req_write_i  in  1  1=write, 0=read
- csr_req_valid_i  in  1  request valid
- csr_req_ready_o  out  1  request accepted when valid&ready
- csr_rsp_data_o  out  DataWidth  read data (0 for writes and errors)
- csr_rsp_err_o  out  1  request rejected
- csr_rsp_valid_o  out  1  response valid
- csr_rsp_ready_i  in  1  response consumed when valid&ready
- csr_busy_i  in  1  core busy, drives lock
- csr_reg_ro_i  in  NumRegs*DataWidth  hardware values for RO registers
- csr_reg_set_o  out  NumRegs*DataWidth  stored register contents to core
- csr_wr_pulse_o  out  NumRegs  one-cycle strobe per successful write

Behaviour:
- Reset: clock is clk_i; reset is rst_ni, asynchronous, active-low. On reset, all stored bits=0, csr_rsp_valid_o=0, csr_rsp_data_o=0, csr_rsp_err_o=0, csr_wr_pulse_o=0. Reset mid-transaction drops the pending response; no response is replayed afterwards.
- Ready rule: csr_req_ready_o = !csr_rsp_valid_o | csr_rsp_ready_i (combinational). One-entry response register; sustained throughput 1 request/cycle.
- Accept edge (E): a request is accepted at the rising edge where valid&ready.
  - At E, the response registers load and csr_rsp_valid_o rises for the cycle after E.
  - Response data and error are held stable while valid&!ready.
  - If no new request is accepted in a cycle where the response is consumed, csr_rsp_valid_o falls.
- Error (err=1, data=0, no state change, no pulse) when any of:
  - addr >= NumRegs;
  - write to an RoRegMask register;
  - write to a LockRegMask register while csr_busy_i=1, sampled at E.
- Successful write:
  - Stored register updates at E; the new value is visible on csr_reg_set_o the cycle after E.
  - csr_wr_pulse_o[i]=1 in that same cycle only.
  - Bits of RO registers are never stored and their csr_reg_set_o slice is 0.
- Self-clear bits:
  - A written 1 is visible on csr_reg_set_o for exactly one cycle, then returns to 0 at the next edge.
  - A back-to-back write of 1 keeps it high for a second cycle.
  - Writing 0 has no effect.
  - Reads always return 0 for these bits.
- Read: csr_rsp_data_o = RO ? csr_reg_ro_i slice sampled at E : stored value with self-clear bits masked to 0.
- Read-after-write: a read of the same register accepted the cycle after a write's E returns the new value.
- csr_busy_i has no effect on reads or on unlocked registers.
- Address uses the full AddrWidth compare; no aliasing or wrap-around.

Test Plan:
- Write reg 4 = 0xDEADBEEF, then read reg 4.
  - -> Write response err=0, data=0; csr_wr_pulse_o[4] high for exactly 1 cycle.
  - -> Read response data=0xDEADBEEF, err=0.
- RoRegMask bit 2 set, csr_reg_ro_i slice 2=0x105.
  - -> Read reg 2 returns 0x105.
  - -> Write reg 2 = 0xFF gives err=1, no pulse, subsequent read still 0x105.
- SelfClrMask bit 0 of reg 0; write reg 0 = 0x9.
  - -> csr_reg_set_o reg0 = 0x9 for 1 cycle, then 0x8.
  - -> Read reg 0 returns 0x8.
- LockRegMask bit 9 set, csr_busy_i=1, write reg 9 = 0x3.
  - -> err=1, reg 9 stays 0.
  - -> With busy=0 the same write succeeds with err=0 and read returns 0x3.
- Read addr 13 and addr 0xFFFF_FFFF.
  - -> err=1, data=0, no register changes.
- Issue 4 back-to-back requests with csr_rsp_ready_i=0 for 3 cycles.
  - -> Only 1 request is accepted; csr_req_ready_o=0 and the response is stable during the stall.
  - -> After ready=1, all 4 complete at 1/cycle in order.
  - -> Assert rst_ni low mid-stream: rsp_valid=0 and all regs 0 immediately.
